// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and the address/data
// widths common to PC, fetch and decode.
package cpu_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts cycles spent waiting on instruction memory and flags when the wait
// reaches TIMEOUT cycles.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th waiting cycle, i.e. as the count reaches TIMEOUT.
  assign expire_c_o = en_i & ~clr_i & (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads memory at the PC, captures the word into IR,
// hands it to decode over valid/ready and requests a PC increment per capture.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    pc_addr,
  input  logic             flush,
  output logic             ipc,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic [DW-1:0]    ir_out,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             err
);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             ipc_q, ipc_d;
  logic             mem_req_q, mem_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wd_clr_c, wd_en_c, wd_expire_c;

  // Watchdog only runs while a request is outstanding and not resolved.
  assign wd_en_c  = (state_q == ST_REQ);
  assign wd_clr_c = (state_q != ST_REQ) | flush | mem_ack;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (wd_clr_c),
    .en_i       (wd_en_c),
    .expire_c_o (wd_expire_c)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ipc_d      = 1'b0;
    cnt_d      = cnt_q;
    err_d      = err_q;

    // A flush outranks any same-cycle ack or decode handshake.
    if (flush && (state_q != ST_IDLE)) begin
      ir_valid_d = 1'b0;
      state_d    = ST_SETTLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && !err_q) begin
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            ir_d       = mem_rdata;
            ir_valid_d = 1'b1;
            ipc_d      = 1'b1;
            state_d    = ST_HOLD;
          end else if (wd_expire_c) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = en ? ST_REQ : ST_IDLE;
          end
        end
        ST_SETTLE: begin
          state_d = en ? ST_REQ : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    mem_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      ipc_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ipc_q      <= ipc_d;
      mem_req_q  <= mem_req_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Address follows the live PC so a REQ entered right after an increment
  // presents the updated value.
  assign mem_addr  = mem_req_q ? pc_addr : '0;
  assign mem_req   = mem_req_q;
  assign ipc       = ipc_q;
  assign ir_out    = ir_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected IR words are queued by the
// stimulus and checked by a monitor on every decode handshake.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst, en, flush, ir_ready;
  logic [5:0] pc;
  logic       ipc, mem_req, mem_ack, ir_valid, err;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata, ir_out, fetch_cnt;

  logic [7:0] mem [64];
  logic       jump, mem_auto, force_ack;
  int         wait_n, req_cnt;

  logic [7:0] exp_q[$];
  logic [7:0] fcnt_m;
  int         ipc_cnt;
  int         total_n = 0;
  int         bad_n   = 0;

  instr_fetch #(.AW(6), .DW(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pc_addr   (pc),
    .flush     (flush),
    .ipc       (ipc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .fetch_cnt (fetch_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  // PC model: jump load beats increment.
  always @(posedge clk) begin
    if (rst)       pc <= 6'd0;
    else if (jump) pc <= 6'h15;
    else if (ipc)  pc <= pc + 6'd1;
  end

  // Memory model: ack after wait_n cycles of request, or forced manually.
  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) req_cnt <= 0;
    else                            req_cnt <= req_cnt + 1;
  end
  assign mem_ack   = mem_req && (mem_auto ? (req_cnt >= wait_n) : force_ack);
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_default();
    for (int a = 0; a < 64; a++) mem[a] = 8'hA0 + 8'(a);
  endtask

  // Monitor: consume one expected word per handshake, count ipc pulses.
  always @(negedge clk) begin
    if (rst) begin
      fcnt_m  = 8'd0;
      ipc_cnt = 0;
    end else begin
      if (ipc) ipc_cnt++;
      if (ir_valid && ir_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 32'd0, 32'd1);
        end else begin
          chk("ir_accept", 32'(ir_out), 32'(exp_q.pop_front()));
          chk("fetch_cnt_at_accept", 32'(fetch_cnt), 32'(fcnt_m));
          fcnt_m = fcnt_m + 8'd1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; flush = 1'b0; ir_ready = 1'b1;
    jump = 1'b0; mem_auto = 1'b1; force_ack = 1'b0; wait_n = 0;
    mem_default();

    // 1: reset
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_ipc", 32'(ipc), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ir_out", 32'(ir_out), 0);
    chk("rst_fetch_cnt", 32'(fetch_cnt), 0);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    rst = 1'b0;
    chk("post_rst_no_req", 32'(mem_req), 0);
    tick();
    chk("first_req", 32'(mem_req), 1);
    chk("first_addr", 32'(mem_addr), 0);

    // 2: straight-line, 0-wait
    tick();
    chk("sl_valid", 32'(ir_valid), 1);
    chk("sl_ipc", 32'(ipc), 1);
    chk("sl_ir", 32'(ir_out), 32'h A0);
    tick();
    chk("sl_ipc_single", 32'(ipc), 0);
    chk("sl_addr1", 32'(mem_addr), 1);
    tick(); tick();
    chk("sl_addr2", 32'(mem_addr), 2);
    en = 1'b0;
    tick(); tick();
    chk("sl_cnt", 32'(fetch_cnt), 3);
    chk("sl_idle_req", 32'(mem_req), 0);
    chk("sl_idle_valid", 32'(ir_valid), 0);
    chk("sl_ipc_cnt", 32'(ipc_cnt), 3);

    // 3: backpressure
    mem[3] = 8'h3C;
    exp_q.push_back(8'h3C);
    ir_ready = 1'b0; en = 1'b1;
    tick();
    chk("bp_addr", 32'(mem_addr), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(ir_valid), 1);
      chk("bp_ir", 32'(ir_out), 32'h3C);
      chk("bp_no_req", 32'(mem_req), 0);
      chk("bp_ipc", 32'(ipc), (i == 0) ? 32'd1 : 32'd0);
    end
    ir_ready = 1'b1; en = 1'b0;
    tick();
    chk("bp_released", 32'(ir_valid), 0);
    chk("bp_cnt", 32'(fetch_cnt), 4);
    chk("bp_ipc_cnt", 32'(ipc_cnt), 4);

    // 4: flush against a same-cycle ack
    mem[4] = 8'hFF;
    exp_q.push_back(8'hB5);
    mem_auto = 1'b0; force_ack = 1'b0; en = 1'b1;
    tick();
    chk("fl_req", 32'(mem_req), 1);
    chk("fl_addr", 32'(mem_addr), 4);
    force_ack = 1'b1; flush = 1'b1; jump = 1'b1;
    tick();
    flush = 1'b0; force_ack = 1'b0; jump = 1'b0; mem_auto = 1'b1;
    chk("fl_settle_req", 32'(mem_req), 0);
    chk("fl_ir_kept", 32'(ir_out), 32'h3C);
    chk("fl_no_valid", 32'(ir_valid), 0);
    chk("fl_no_ipc", 32'(ipc), 0);
    tick();
    chk("fl_new_req", 32'(mem_req), 1);
    chk("fl_new_addr", 32'(mem_addr), 32'h15);
    en = 1'b0;
    tick();
    chk("fl_ir_new", 32'(ir_out), 32'hB5);
    tick();
    chk("fl_cnt", 32'(fetch_cnt), 5);
    chk("fl_ipc_cnt", 32'(ipc_cnt), 5);

    // 5: memory timeout
    mem_auto = 1'b0; force_ack = 1'b0; en = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req) n++;
      if (err) break;
    end
    chk("to_req_cycles", 32'(n), 15);
    chk("to_err", 32'(err), 1);
    chk("to_req_drop", 32'(mem_req), 0);
    repeat (4) tick();
    chk("to_stay_idle", 32'(mem_req), 0);
    chk("to_sticky", 32'(err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_rst_err", 32'(err), 0);
    chk("to_rst_cnt", 32'(fetch_cnt), 0);
    chk("to_rst_ir", 32'(ir_out), 0);

    // 6: 255 fast fetches, then a wait-state fetch with en dropped, cnt wraps
    mem_default();
    mem_auto = 1'b1; wait_n = 0; ir_ready = 1'b1;
    for (int k = 0; k < 256; k++) exp_q.push_back(8'hA0 + 8'(k % 64));
    repeat (510) tick();
    chk("ws_cnt_254", 32'(fetch_cnt), 254);
    wait_n = 3;
    tick();
    chk("ws_req", 32'(mem_req), 1);
    chk("ws_addr", 32'(mem_addr), 63);
    chk("ws_cnt_255", 32'(fetch_cnt), 255);
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (ir_valid) break;
    end
    chk("ws_wait_cycles", 32'(n), 4);
    chk("ws_ir", 32'(ir_out), 32'hDF);
    tick();
    chk("ws_wrap", 32'(fetch_cnt), 0);
    chk("ws_idle_valid", 32'(ir_valid), 0);
    repeat (3) tick();
    chk("ws_idle_req", 32'(mem_req), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
